// File: rtl/branch_controller.sv
// branch_controller: ID-stage branch/jump control with load-use hazard stalls
// and resolved/taken branch statistics.
module branch_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  IFIDinstr,
    input  logic [4:0]  IFIDrs,
    input  logic [4:0]  IFIDrt,
    input  logic        IDEXregWrite,
    input  logic        IDEXmemRead,
    input  logic [4:0]  IDEXrd,
    input  logic        EXMEMmemRead,
    input  logic [4:0]  EXMEMrd,
    input  logic        zero,
    output logic        stall,
    output logic        IFFlush,
    output logic        PCSrc,
    output logic        jump,
    output logic [15:0] branchCount,
    output logic [15:0] takenCount
);
    typedef enum logic [1:0] {IDLE, STALL, RESOLVE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] bc_q, bc_d, tc_q, tc_d;
    logic        is_beq, is_bne, is_branch, is_jump;
    logic        match_ex, match_mem, taken, hazard, decide;
    logic [1:0]  depth;

    assign is_beq    = IFIDinstr == 6'b000100;
    assign is_bne    = IFIDinstr == 6'b000101;
    assign is_jump   = IFIDinstr == 6'b000010;
    assign is_branch = is_beq || is_bne;
    // register $0 never creates a dependency
    assign match_ex  = (IFIDrs != 5'd0 && IFIDrs == IDEXrd) || (IFIDrt != 5'd0 && IFIDrt == IDEXrd);
    assign match_mem = (IFIDrs != 5'd0 && IFIDrs == EXMEMrd) || (IFIDrt != 5'd0 && IFIDrt == EXMEMrd);
    assign depth     = (IDEXmemRead && match_ex) ? 2'd2 :
                       ((IDEXregWrite && match_ex) || (EXMEMmemRead && match_mem)) ? 2'd1 : 2'd0;
    assign hazard    = state_q == IDLE && is_branch && depth != 2'd0;
    assign taken     = (is_beq && zero) || (is_bne && !zero);
    assign decide    = (state_q == IDLE && is_branch && depth == 2'd0) || state_q == RESOLVE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            bc_q    <= 16'd0;
            tc_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bc_q    <= bc_d;
            tc_q    <= tc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = 2'd0;
        bc_d    = decide ? bc_q + 16'd1 : bc_q;
        tc_d    = (decide && taken) ? tc_q + 16'd1 : tc_q;
        case (state_q)
            IDLE: if (hazard) begin
                state_d = depth == 2'd2 ? STALL : RESOLVE;
                cnt_d   = depth - 2'd1;
            end
            STALL: begin
                state_d = RESOLVE;
                cnt_d   = cnt_q - 2'd1;
            end
            RESOLVE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // outputs are gated by rst_n so they clear asynchronously with the state
    always_comb begin
        stall       = rst_n && (hazard || state_q == STALL);
        jump        = rst_n && state_q == IDLE && is_jump;
        PCSrc       = rst_n && decide && taken;
        IFFlush     = rst_n && ((state_q == IDLE && is_jump) || (decide && taken));
        branchCount = bc_q;
        takenCount  = tc_q;
    end
endmodule

// File: tb/tb_branch_controller.sv
// tb_branch_controller: randomized scoreboard bench for branch_controller.
module tb_branch_controller;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  IFIDinstr = 6'd0;
    logic [4:0]  IFIDrs = 5'd0, IFIDrt = 5'd0, IDEXrd = 5'd0, EXMEMrd = 5'd0;
    logic        IDEXregWrite = 1'b0, IDEXmemRead = 1'b0, EXMEMmemRead = 1'b0, zero = 1'b0;
    logic        stall, IFFlush, PCSrc, jump;
    logic [15:0] branchCount, takenCount;

    branch_controller dut (
        .clk(clk), .rst_n(rst_n), .IFIDinstr(IFIDinstr), .IFIDrs(IFIDrs), .IFIDrt(IFIDrt),
        .IDEXregWrite(IDEXregWrite), .IDEXmemRead(IDEXmemRead), .IDEXrd(IDEXrd),
        .EXMEMmemRead(EXMEMmemRead), .EXMEMrd(EXMEMrd), .zero(zero),
        .stall(stall), .IFFlush(IFFlush), .PCSrc(PCSrc), .jump(jump),
        .branchCount(branchCount), .takenCount(takenCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  ctl;
        logic [15:0] bc;
        logic [15:0] tc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0, failures = 0;
    bit          mon_en = 1'b0;
    logic [15:0] exp_bc = 16'd0, exp_tc = 16'd0;

    localparam logic [5:0] OP_J = 6'b000010, OP_BEQ = 6'b000100, OP_BNE = 6'b000101;

    always @(negedge clk) if (mon_en) begin
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_underflow: monitor active with no expected cycle");
        end else begin
            exp_t e;
            e = q.pop_front();
            if ({stall, IFFlush, PCSrc, jump} !== e.ctl || branchCount !== e.bc || takenCount !== e.tc) begin
                failures++;
                $display("FAIL cycle t=%0t: got ctl(stall,flush,pcsrc,jump)=%b bc=%h tc=%h, want ctl=%b bc=%h tc=%h",
                         $time, {stall, IFFlush, PCSrc, jump}, branchCount, takenCount, e.ctl, e.bc, e.tc);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Number of extra ID cycles a branch waits for its operands.
    function automatic int depth_of(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                    input logic iw, input logic imr, input logic [4:0] ird,
                                    input logic emr, input logic [4:0] erd);
        bit uses_ex  = (rs != 0 && rs == ird) || (rt != 0 && rt == ird);
        bit uses_mem = (rs != 0 && rs == erd) || (rt != 0 && rt == erd);
        if (op != OP_BEQ && op != OP_BNE) return 0;
        if (imr && uses_ex) return 2;
        if ((iw && uses_ex) || (emr && uses_mem)) return 1;
        return 0;
    endfunction

    task automatic push(input logic [3:0] ctl);
        exp_t e;
        e.ctl = ctl; e.bc = exp_bc; e.tc = exp_tc;
        q.push_back(e);
    endtask

    // Present one instruction in IF/ID until it leaves ID; scramble younger-stage
    // hazard inputs while stalled when shake is set.
    task automatic do_instr(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                            input logic iw, input logic imr, input logic [4:0] ird,
                            input logic emr, input logic [4:0] erd, input logic z, input bit shake);
        int d = depth_of(op, rs, rt, iw, imr, ird, emr, erd);
        IFIDinstr = op; IFIDrs = rs; IFIDrt = rt; IDEXregWrite = iw; IDEXmemRead = imr;
        IDEXrd = ird; EXMEMmemRead = emr; EXMEMrd = erd; zero = z;
        for (int i = 0; i <= d; i++) begin
            if (i > 0 && shake) begin
                IDEXregWrite = 1'($urandom); IDEXmemRead = 1'($urandom); EXMEMmemRead = 1'($urandom);
                IDEXrd = 5'($urandom_range(0, 3)); EXMEMrd = 5'($urandom_range(0, 3));
            end
            if (i < d) push(4'b1000);
            else if (op == OP_J) push(4'b0101);
            else if (op == OP_BEQ || op == OP_BNE) begin
                bit tk = (op == OP_BEQ) ? z : !z;
                push({1'b0, tk, tk, 1'b0});
                exp_bc = exp_bc + 16'd1;
                exp_tc = exp_tc + 16'(tk);
            end else push(4'b0000);
            @(posedge clk); #1;
        end
    endtask

    task automatic rand_instr();
        int r = $urandom_range(0, 5);
        logic [5:0] op = r == 0 ? OP_J : r <= 2 ? OP_BEQ : r <= 4 ? OP_BNE : 6'($urandom);
        do_instr(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                 5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom), 1'b1);
    endtask

    initial begin
        IFIDinstr = OP_BEQ; zero = 1'b1;
        #3;
        check("reset_outputs", {28'd0, stall, IFFlush, PCSrc, jump}, 32'd0);
        check("reset_counters", {branchCount, takenCount}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        do_instr(OP_BEQ, 5'd3, 5'd4, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        do_instr(OP_BNE, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 1'b0);
        do_instr(OP_BEQ, 5'd0, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0);
        do_instr(OP_BEQ, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        do_instr(OP_J, 5'd1, 5'd1, 1'b1, 1'b1, 5'd1, 1'b1, 5'd1, 1'b0, 1'b0);
        do_instr(OP_BNE, 5'd2, 5'd1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd1, 1'b0, 1'b1);
        for (int i = 0; i < 400; i++) rand_instr();
        // Reset while a depth-2 branch is parked in STALL.
        IFIDinstr = OP_BNE; IFIDrs = 5'd5; IFIDrt = 5'd0; IDEXmemRead = 1'b1; IDEXrd = 5'd5;
        IDEXregWrite = 1'b0; EXMEMmemRead = 1'b0; zero = 1'b0;
        push(4'b1000);
        @(posedge clk); #1;
        mon_en = 1'b0;
        check("stall_before_reset", {31'd0, stall}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {28'd0, stall, IFFlush, PCSrc, jump}, 32'd0);
        check("async_reset_counters", {branchCount, takenCount}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_bc = 16'd0; exp_tc = 16'd0; q.delete();
        mon_en = 1'b1;
        // After release the held opcode is evaluated fresh from IDLE.
        do_instr(OP_BNE, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 65534; i++)
            do_instr(OP_BEQ, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'(i[0]), 1'b0);
        check("count_preload_ffff", {16'd0, branchCount}, 32'h0000_FFFF);
        do_instr(OP_BNE, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        check("count_wrap_0000", {16'd0, branchCount}, 32'h0000_0000);
        for (int i = 0; i < 50; i++) rand_instr();
        mon_en = 1'b0;
        check("scoreboard_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_controller.md
BRANCH_CONTROLLER -- requirements
Module: branch_controller

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port IFIDinstr, input, 6, opcode of instruction in IF/ID (000010 j, 000100 beq, 000101 bne).
REQ-004 SHALL have ports IFIDrs and IFIDrt, input, 5 each, source registers of IF/ID instruction.
REQ-005 SHALL have ports IDEXregWrite and IDEXmemRead, input, 1 each, control bits of instruction in EX.
REQ-006 SHALL have port IDEXrd, input, 5, destination register of instruction in EX.
REQ-007 SHALL have ports EXMEMmemRead (input, 1) and EXMEMrd (input, 5), load flag and destination of instruction in MEM.
REQ-008 SHALL have port zero, input, 1, equality flag from the ID-stage branch comparator (readData1 == readData2).
REQ-009 SHALL have port stall, output, 1, holds PC and IF/ID and forces bubble into ID/EX.
REQ-010 SHALL have ports IFFlush, PCSrc, jump, output, 1 each, same meaning as the existing ID-stage branch control signals.
REQ-011 SHALL have ports branchCount and takenCount, output, 16 each, resolved-branch and taken-branch counters.

Function
REQ-012 SHALL implement FSM states IDLE, STALL, RESOLVE; state, stall counter (2 bits) and counters are registered; stall, IFFlush, PCSrc, jump are combinational from state and inputs.
REQ-013 SHALL define isBranch = IFIDinstr in {000100, 000101}.
REQ-014 SHALL define a source match only for nonzero register numbers: src = (IFIDrs != 0 and equal) or (IFIDrt != 0 and equal).
REQ-015 SHALL compute hazard depth in IDLE for isBranch: 2 if IDEXmemRead and src match IDEXrd; else 1 if (IDEXregWrite and src match IDEXrd) or (EXMEMmemRead and src match EXMEMrd); else 0; the larger depth wins when several conditions are true.
REQ-016 IDLE, isBranch, depth > 0: stall=1, IFFlush=PCSrc=jump=0; load counter with depth-1; next state STALL if depth=2, else RESOLVE.
REQ-017 STALL: stall=1, other outputs 0; next state RESOLVE; IFIDinstr is held stable by stall.
REQ-018 Decision (IDLE with isBranch and depth=0, or RESOLVE): taken = (beq and zero=1) or (bne and zero=0); PCSrc=IFFlush=taken; stall=0; jump=0; next state IDLE.
REQ-019 Decision cycle: branchCount increments by 1; takenCount increments by 1 when taken; both wrap 0xFFFF -> 0x0000.
REQ-020 IDLE, IFIDinstr=000010: jump=1, IFFlush=1, PCSrc=0, stall=0; no hazard check; counters unchanged; remains IDLE.
REQ-021 IDLE, any other opcode: all control outputs 0; remains IDLE.
REQ-022 RESOLVE uses the opcode held in IF/ID and SHALL NOT re-run hazard detection.
REQ-023 Latency: no-hazard branch resolves in its first ID cycle; depth 1 adds 1 stall cycle; depth 2 adds 2 stall cycles.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, stall counter 0, branchCount=takenCount=0, and all control outputs to 0 regardless of clk.
REQ-025 Reset asserted during STALL or RESOLVE SHALL discard the pending branch without counter update; after release the FSM SHALL evaluate IFIDinstr from IDLE.

Verification
REQ-026 beq, rs=3, rt=4, no matches, zero=1 -> same cycle PCSrc=1, IFFlush=1, stall=0; branchCount=1, takenCount=1 next edge.
REQ-027 bne, rs=5, IDEXmemRead=1, IDEXrd=5, zero=1 -> stall=1 for 2 cycles (IDLE, STALL), then RESOLVE with PCSrc=0, IFFlush=0; branchCount+1, takenCount unchanged.
REQ-028 beq, rt=7, IDEXregWrite=1, IDEXrd=7, EXMEMmemRead=1, EXMEMrd=7 -> exactly 1 stall cycle, then decision; with rs=rt=0 and IDEXrd=0 -> no stall.
REQ-029 IFIDinstr=000010 -> jump=1, IFFlush=1, PCSrc=0, stall=0, counters unchanged.
REQ-030 branchCount preloaded to 0xFFFF through 65535 resolved branches, then one more -> branchCount=0x0000; rst_n pulsed low during STALL -> outputs 0 and counters 0 asynchronously.
